// File: rtl/fir_decim_mc_if.sv
// rtl/fir_decim_mc_if.sv - upstream/downstream FIFO handshake bundle for fir_decim_mc
interface fir_decim_mc_if #(
  parameter int CHANNELS   = 2,
  parameter int DATA_WIDTH = 32
);
  logic [CHANNELS-1:0][DATA_WIDTH-1:0] in_data;
  logic                                in_empty;
  logic                                in_rd_en;
  logic [CHANNELS-1:0][DATA_WIDTH-1:0] out_data;
  logic                                out_full;
  logic                                out_wr_en;

  modport master (
    output in_data, in_empty, out_full,
    input  in_rd_en, out_data, out_wr_en
  );

  modport slave (
    input  in_data, in_empty, out_full,
    output in_rd_en, out_data, out_wr_en
  );
endinterface

// File: rtl/fir_decim_mc.sv
// rtl/fir_decim_mc.sv - multi-channel decimating FIR, MULT_PER_CYCLE taps per channel per cycle
module fir_decim_mc #(
  parameter int TAP_COUNT      = 32,
  parameter int DECIMATION     = 1,
  parameter int MULT_PER_CYCLE = 4,
  parameter int CHANNELS       = 2,
  parameter int DATA_WIDTH     = 32,
  parameter int FRAC_BITS      = 10,
  parameter int ACC_WIDTH      = 2*DATA_WIDTH+8
) (
  input  logic                                 clock,
  input  logic                                 reset,
  input  logic [TAP_COUNT-1:0][DATA_WIDTH-1:0] taps,
  fir_decim_mc_if.slave                        bus
);

  localparam int M    = TAP_COUNT / MULT_PER_CYCLE;
  localparam int MC_W = (M > 1) ? $clog2(M) : 1;
  localparam int DC_W = $clog2(DECIMATION + 1);
  localparam int TI_W = (TAP_COUNT > 1) ? $clog2(TAP_COUNT) : 1;
  localparam int PW   = 2 * DATA_WIDTH;

  localparam logic signed [ACC_WIDTH:0] HALF = {{ACC_WIDTH{1'b0}}, 1'b1} << (FRAC_BITS - 1);
  localparam logic signed [ACC_WIDTH:0] MAXV = {{(ACC_WIDTH + 2 - DATA_WIDTH){1'b0}}, {(DATA_WIDTH - 1){1'b1}}};
  localparam logic signed [ACC_WIDTH:0] MINV = ~MAXV;

  typedef enum logic [1:0] {SHIFT, MAC, OUTPUT} state_t;

  state_t                              state_q, state_d;
  logic [DC_W-1:0]                     dec_cnt_q, dec_cnt_d;
  logic [MC_W-1:0]                     mac_cnt_q, mac_cnt_d;
  logic signed [DATA_WIDTH-1:0]        hist_q [CHANNELS][TAP_COUNT];
  logic signed [DATA_WIDTH-1:0]        hist_d [CHANNELS][TAP_COUNT];
  logic signed [ACC_WIDTH-1:0]         acc_q [CHANNELS];
  logic signed [ACC_WIDTH-1:0]         acc_d [CHANNELS];
  logic signed [ACC_WIDTH-1:0]         acc_sum [CHANNELS];
  logic [CHANNELS-1:0][DATA_WIDTH-1:0] out_data_q, out_data_d;
  logic [TI_W-1:0]                     idx;
  logic signed [PW-1:0]                prod;
  logic                                rd_en, wr_en;

  // Round half toward +inf on the full-precision sum, then clamp to the sample range.
  function automatic logic [DATA_WIDTH-1:0] quantize(input logic signed [ACC_WIDTH-1:0] a);
    logic signed [ACC_WIDTH:0] r;
    r = ($signed({a[ACC_WIDTH-1], a}) + HALF) >>> FRAC_BITS;
    if (r > MAXV)      return MAXV[DATA_WIDTH-1:0];
    else if (r < MINV) return MINV[DATA_WIDTH-1:0];
    else               return r[DATA_WIDTH-1:0];
  endfunction

  always_comb begin
    state_d    = state_q;
    dec_cnt_d  = dec_cnt_q;
    mac_cnt_d  = mac_cnt_q;
    hist_d     = hist_q;
    acc_d      = acc_q;
    out_data_d = out_data_q;
    idx        = '0;
    prod       = '0;
    rd_en      = (state_q == SHIFT) && !bus.in_empty;
    wr_en      = (state_q == OUTPUT) && !bus.out_full;

    for (int c = 0; c < CHANNELS; c++) begin
      acc_sum[c] = acc_q[c];
      for (int j = 0; j < MULT_PER_CYCLE; j++) begin
        idx        = TI_W'(int'(mac_cnt_q) * MULT_PER_CYCLE + j);
        prod       = PW'($signed(taps[idx])) * PW'(hist_q[c][idx]);
        acc_sum[c] = acc_sum[c] + ACC_WIDTH'(prod);
      end
    end

    case (state_q)
      SHIFT: begin
        if (rd_en) begin
          for (int c = 0; c < CHANNELS; c++) begin
            for (int k = TAP_COUNT - 1; k > 0; k--) hist_d[c][k] = hist_q[c][k-1];
            hist_d[c][0] = $signed(bus.in_data[c]);
          end
          if (dec_cnt_q == DC_W'(DECIMATION - 1)) begin
            dec_cnt_d = '0;
            mac_cnt_d = '0;
            for (int c = 0; c < CHANNELS; c++) acc_d[c] = '0;
            state_d   = MAC;
          end else begin
            dec_cnt_d = dec_cnt_q + DC_W'(1);
          end
        end
      end
      MAC: begin
        acc_d     = acc_sum;
        mac_cnt_d = mac_cnt_q + MC_W'(1);
        if (mac_cnt_q == MC_W'(M - 1)) begin
          for (int c = 0; c < CHANNELS; c++) out_data_d[c] = quantize(acc_sum[c]);
          state_d = OUTPUT;
        end
      end
      OUTPUT: begin
        if (wr_en) state_d = SHIFT;
      end
      default: state_d = SHIFT;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= SHIFT;
      dec_cnt_q  <= '0;
      mac_cnt_q  <= '0;
      hist_q     <= '{default: '0};
      acc_q      <= '{default: '0};
      out_data_q <= '0;
    end else begin
      state_q    <= state_d;
      dec_cnt_q  <= dec_cnt_d;
      mac_cnt_q  <= mac_cnt_d;
      hist_q     <= hist_d;
      acc_q      <= acc_d;
      out_data_q <= out_data_d;
    end
  end

  assign bus.in_rd_en  = rd_en;
  assign bus.out_wr_en = wr_en;
  assign bus.out_data  = out_data_q;

endmodule

// File: tb/tb_fir_decim_mc.sv
// tb/tb_fir_decim_mc.sv - directed bench: identity, impulse, decimation, rounding, backpressure, reset abort
module tb_fir_decim_mc;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic [31:0][31:0] taps_a;
  logic [31:0][15:0] taps_b;
  int total = 0;
  int bad   = 0;

  always #5 clock = ~clock;

  fir_decim_mc_if #(.CHANNELS(2), .DATA_WIDTH(32)) ifa ();
  fir_decim_mc_if #(.CHANNELS(2), .DATA_WIDTH(16)) ifb ();

  fir_decim_mc #(.TAP_COUNT(32), .DECIMATION(1), .MULT_PER_CYCLE(4), .CHANNELS(2),
                 .DATA_WIDTH(32), .FRAC_BITS(10)) dut_a (
    .clock(clock), .reset(reset), .taps(taps_a), .bus(ifa));

  fir_decim_mc #(.TAP_COUNT(32), .DECIMATION(4), .MULT_PER_CYCLE(4), .CHANNELS(2),
                 .DATA_WIDTH(16), .FRAC_BITS(10)) dut_b (
    .clock(clock), .reset(reset), .taps(taps_b), .bus(ifb));

  task automatic check(input string tag, input longint got, input longint exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b1;
    ifa.in_empty = 1'b1; ifb.in_empty = 1'b1;
    ifa.out_full = 1'b0; ifb.out_full = 1'b0;
    @(negedge clock);
    check("rst_rd", {ifa.in_rd_en, ifb.in_rd_en}, 0);
    check("rst_wr", {ifa.out_wr_en, ifb.out_wr_en}, 0);
    reset = 1'b0;
  endtask

  task automatic push_a(input int x0, input int x1);
    int n = 0;
    @(negedge clock);
    ifa.in_data[0] = x0; ifa.in_data[1] = x1; ifa.in_empty = 1'b0;
    #1;
    while (!ifa.in_rd_en && n < 50) begin @(negedge clock); #1; n++; end
    check("push_a_ok", n < 50, 1);
    @(posedge clock); #1 ifa.in_empty = 1'b1;
  endtask

  task automatic push_b(input int x0, input int x1);
    int n = 0;
    @(negedge clock);
    ifb.in_data[0] = 16'(x0); ifb.in_data[1] = 16'(x1); ifb.in_empty = 1'b0;
    #1;
    while (!ifb.in_rd_en && n < 50) begin @(negedge clock); #1; n++; end
    check("push_b_ok", n < 50, 1);
    @(posedge clock); #1 ifb.in_empty = 1'b1;
  endtask

  task automatic wait_out_a(output longint y0, output longint y1, output int lat);
    lat = 0;
    do begin @(negedge clock); lat++; end while (!ifa.out_wr_en && lat < 100);
    check("wait_a_ok", ifa.out_wr_en, 1);
    y0 = longint'($signed(ifa.out_data[0]));
    y1 = longint'($signed(ifa.out_data[1]));
    @(posedge clock); #1;
  endtask

  task automatic wait_out_b(output longint y0, output longint y1);
    int n = 0;
    do begin @(negedge clock); n++; end while (!ifb.out_wr_en && n < 100);
    check("wait_b_ok", ifb.out_wr_en, 1);
    y0 = longint'($signed(ifb.out_data[0]));
    y1 = longint'($signed(ifb.out_data[1]));
    @(posedge clock); #1;
  endtask

  task automatic impulse_a(input string tag);
    longint y0, y1;
    int lat;
    for (int k = 0; k < 32; k++) taps_a[k] = 32'(1024 * (k + 1));
    for (int i = 0; i <= 32; i++) begin
      push_a((i == 0) ? 1 : 0, 0);
      wait_out_a(y0, y1, lat);
      check({tag, "_ch0"}, y0, (i < 32) ? i + 1 : 0);
      check({tag, "_ch1"}, y1, 0);
    end
  endtask

  initial begin
    longint y0, y1;
    int lat, wr, rd, chg, excl, nout, idx, rd_cnt, n;
    ifa.in_data = '0; ifa.in_empty = 1'b1; ifa.out_full = 1'b0;
    ifb.in_data = '0; ifb.in_empty = 1'b1; ifb.out_full = 1'b0;
    taps_a = '0; taps_b = '0;
    #12;
    check("rst_out_a", ifa.out_data, 0);
    check("rst_out_b", ifb.out_data, 0);
    check("rst_flags", {ifa.in_rd_en, ifa.out_wr_en, ifb.in_rd_en, ifb.out_wr_en}, 0);
    @(negedge clock); reset = 1'b0;

    // identity: one tap of 1.0
    taps_a[0] = 32'd1024;
    push_a(5, -7);
    wait_out_a(y0, y1, lat);
    check("id0_ch0", y0, 5); check("id0_ch1", y1, -7); check("id0_lat", lat, 9);
    push_a(100, 0);
    wait_out_a(y0, y1, lat);
    check("id1_ch0", y0, 100); check("id1_ch1", y1, 0); check("id1_lat", lat, 9);

    do_reset();
    impulse_a("imp");

    // backpressure with identity taps
    taps_a = '0; taps_a[0] = 32'd1024;
    ifa.out_full = 1'b1;
    push_a(3, 4);
    repeat (9) @(negedge clock);
    ifa.in_data[0] = 32'd7; ifa.in_data[1] = 32'd8; ifa.in_empty = 1'b0;
    wr = 0; rd = 0; chg = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clock); #1;
      if (ifa.out_wr_en) wr++;
      if (ifa.in_rd_en) rd++;
      if (ifa.out_data[0] != 32'd3 || ifa.out_data[1] != 32'd4) chg++;
    end
    check("bp_wr", wr, 0); check("bp_rd", rd, 0); check("bp_stable", chg, 0);
    ifa.out_full = 1'b0;
    wr = 0; rd = 0;
    for (int i = 0; i < 6; i++) begin
      #1;
      if (ifa.out_wr_en) wr++;
      if (ifa.in_rd_en) rd++;
      @(posedge clock);
      if (rd > 0) #1 ifa.in_empty = 1'b1;
      @(negedge clock);
    end
    check("bp_rel_wr", wr, 1); check("bp_rel_rd", rd, 1);
    wait_out_a(y0, y1, lat);
    check("bp_next_ch0", y0, 7); check("bp_next_ch1", y1, 8);

    // reset in the middle of MAC aborts the result
    for (int k = 0; k < 32; k++) taps_a[k] = 32'(1024 * (k + 1));
    push_a(1, 0);
    @(posedge clock); @(posedge clock); #1;
    reset = 1'b1;
    @(negedge clock);
    check("mid_rst_wr", ifa.out_wr_en, 0);
    @(negedge clock); reset = 1'b0;
    wr = 0;
    for (int i = 0; i < 20; i++) begin @(negedge clock); if (ifa.out_wr_en) wr++; end
    check("mid_rst_nowr", wr, 0);
    impulse_a("imp2");

    // decimation by 4 on a ramp
    do_reset();
    taps_b[0] = 16'd1024;
    idx = 0; nout = 0; rd_cnt = 0; n = 0; excl = 0;
    while (nout < 3 && n < 300) begin
      @(negedge clock);
      ifb.in_empty = (idx >= 12);
      ifb.in_data[0] = 16'(idx + 1); ifb.in_data[1] = '0;
      #1;
      if (ifb.in_rd_en && ifb.out_wr_en) excl++;
      if (ifb.in_rd_en) begin rd_cnt++; idx++; end
      if (ifb.out_wr_en) begin
        check("dec_out", longint'($signed(ifb.out_data[0])), 4 * (nout + 1));
        check("dec_ch1", longint'($signed(ifb.out_data[1])), 0);
        check("dec_rd", rd_cnt, 4);
        rd_cnt = 0; nout++;
      end
      n++;
    end
    ifb.in_empty = 1'b1;
    check("dec_done", nout, 3); check("dec_excl", excl, 0);

    // rounding: 0.5 gain
    do_reset();
    taps_b = '0; taps_b[0] = 16'd512;
    repeat (4) push_b(3, -3);
    wait_out_b(y0, y1);
    check("rnd_pos", y0, 2); check("rnd_neg", y1, -1);

    // saturation: all taps at full scale
    do_reset();
    for (int k = 0; k < 32; k++) taps_b[k] = 16'd32767;
    repeat (4) push_b(32767, -32768);
    wait_out_b(y0, y1);
    check("sat_pos", y0, 32767); check("sat_neg", y1, -32768);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
